// File: rtl/led_frame_scheduler.sv
// Frame sequencer for led_driver: fetches NUM_LED pixel words from a synchronous
// RAM, hands them to the driver one at a time, then holds the strip latch gap.
module led_frame_scheduler #(
  parameter int NUM_LED        = 10,
  parameter int LATCH_CYCLES   = 8000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int IDX_W          = (NUM_LED > 1) ? $clog2(NUM_LED) : 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic             continuous_in,
  output logic [IDX_W-1:0] pixel_addr_out,
  input  logic [23:0]      pixel_data_in,
  output logic [23:0]      led_rgb_out,
  output logic             led_valid_out,
  input  logic             led_finished_in,
  output logic             busy_out,
  output logic             frame_done_out,
  output logic             error_out
);
  localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LED - 1);
  localparam logic [LAT_W-1:0] LAT_TC   = LAT_W'(LATCH_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_TC    = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_LATCH} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [23:0]      rgb_q, rgb_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lat_cnt_d = lat_cnt_q;
    to_cnt_d  = to_cnt_q;
    rgb_d     = rgb_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        // Only an explicit start clears a previous timeout; auto-restart keeps it.
        if (start_in || continuous_in) begin
          if (start_in) err_d = 1'b0;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        rgb_d    = pixel_data_in;
        valid_d  = 1'b1;
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (led_finished_in) begin
          if (idx_q == LAST_IDX) begin
            lat_cnt_d = '0;
            state_d   = S_LATCH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end else if (to_cnt_q == TO_TC) begin
          err_d     = 1'b1;
          lat_cnt_d = '0;
          state_d   = S_LATCH;
        end
      end
      S_LATCH: begin
        if (lat_cnt_q == LAT_TC) begin
          lat_cnt_d = '0;
          done_d    = 1'b1;
          if (continuous_in) begin
            idx_d   = '0;
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      lat_cnt_q <= '0;
      to_cnt_q  <= '0;
      rgb_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lat_cnt_q <= lat_cnt_d;
      to_cnt_q  <= to_cnt_d;
      rgb_q     <= rgb_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign pixel_addr_out = idx_q;
  assign led_rgb_out    = rgb_q;
  assign led_valid_out  = valid_q;
  assign busy_out       = busy_q;
  assign frame_done_out = done_q;
  assign error_out      = err_q;
endmodule

// File: tb/tb_led_frame_scheduler.sv
// Bench for led_frame_scheduler: cycle table for one frame, event-trace model
// for directed and random frames, plus a mid-frame reset sequence.
module tb_led_frame_scheduler;
  localparam int N = 3, L = 20, T = 64;
  localparam int EV_VALID = 0, EV_ERR_SET = 1, EV_ERR_CLR = 2, EV_DONE = 3, EV_IDLE = 4;

  logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, cont = 1'b0, fin = 1'b0;
  logic [1:0]  addr;
  logic [23:0] pix, rgb;
  logic        valid, busy, done, err;
  logic [23:0] ram [0:3];
  int          checks = 0, failures = 0;

  typedef struct { int t; int kind; logic [23:0] data; int addr; } ev_t;
  typedef struct { int rep; bit st; bit fn; bit ev; bit eb; bit ed; int ea; logic [23:0] er; } vec_t;

  ev_t  exp_q[$], act_q[$];
  vec_t tbl[$];
  int   dly [0:15];
  bit   m_err;

  led_frame_scheduler #(.NUM_LED(N), .LATCH_CYCLES(L), .TIMEOUT_CYCLES(T)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .continuous_in(cont),
    .pixel_addr_out(addr), .pixel_data_in(pix), .led_rgb_out(rgb),
    .led_valid_out(valid), .led_finished_in(fin), .busy_out(busy),
    .frame_done_out(done), .error_out(err));

  always #5 clk = ~clk;
  always @(posedge clk) pix <= ram[addr];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected event trace derived from the frame timing rules:
  // valid 3 cycles after the request, next valid finish+3, latch gap L after
  // the last finish, error T cycles after a valid nobody answers.
  task automatic build_model(input bit cmode, input int nfr, output int last_done);
    int fetch, v, latch, k;
    k = 0; fetch = 1; last_done = 0;
    exp_q.delete();
    if (!cmode && m_err) begin
      exp_q.push_back(ev_t'{1, EV_ERR_CLR, 24'h0, 0});
      m_err = 1'b0;
    end
    for (int f = 0; f < nfr; f++) begin
      v = fetch + 2; latch = 0;
      for (int i = 0; i < N; i++) begin
        exp_q.push_back(ev_t'{v, EV_VALID, ram[i], i});
        if (dly[k] >= T) begin
          if (!m_err) exp_q.push_back(ev_t'{v + T, EV_ERR_SET, 24'h0, 0});
          m_err = 1'b1;
          latch = v + T;
          k++;
          break;
        end
        if (i == N - 1) latch = v + dly[k] + 1;
        else            v = v + dly[k] + 3;
        k++;
      end
      last_done = latch + L;
      exp_q.push_back(ev_t'{last_done, EV_DONE, 24'h0, 0});
      fetch = last_done;
    end
    exp_q.push_back(ev_t'{last_done, EV_IDLE, 24'h0, 0});
  endtask

  task automatic run_scn(input string tag, input bit cmode, input int nfr);
    int last_done, k, fin_at, mid_st, n;
    bit pv_err, pv_busy;
    build_model(cmode, nfr, last_done);
    act_q.delete();
    k = 0; fin_at = -1; mid_st = -1;
    @(negedge clk);
    pv_err = err; pv_busy = busy;
    for (int t = 0; t <= last_done + 6; t++) begin
      if (t > 0) begin
        @(negedge clk);
        if (valid) begin
          act_q.push_back(ev_t'{t, EV_VALID, rgb, int'(addr)});
          fin_at = t + ((k < 16) ? dly[k] : 5);
          k++;
          if (mid_st < 0) mid_st = t + 5;
        end
        if (err && !pv_err) act_q.push_back(ev_t'{t, EV_ERR_SET, 24'h0, 0});
        if (!err && pv_err) act_q.push_back(ev_t'{t, EV_ERR_CLR, 24'h0, 0});
        if (done) act_q.push_back(ev_t'{t, EV_DONE, 24'h0, 0});
        if (!busy && pv_busy) act_q.push_back(ev_t'{t, EV_IDLE, 24'h0, 0});
        pv_err = err; pv_busy = busy;
      end
      start = !cmode && (t == 0 || t == mid_st);
      cont  = cmode && (t < last_done - 5);
      fin   = (t == fin_at);
    end
    start = 1'b0; cont = 1'b0; fin = 1'b0;
    n = (exp_q.size() > act_q.size()) ? exp_q.size() : act_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (i >= act_q.size()) begin
        failures++;
        $display("FAIL %s ev%0d: missing, expected t=%0d kind=%0d", tag, i, exp_q[i].t, exp_q[i].kind);
      end else if (i >= exp_q.size()) begin
        failures++;
        $display("FAIL %s ev%0d: got t=%0d kind=%0d, expected none", tag, i, act_q[i].t, act_q[i].kind);
      end else if (act_q[i] != exp_q[i]) begin
        failures++;
        $display("FAIL %s ev%0d: got t=%0d kind=%0d data=%h addr=%0d, expected t=%0d kind=%0d data=%h addr=%0d",
                 tag, i, act_q[i].t, act_q[i].kind, act_q[i].data, act_q[i].addr,
                 exp_q[i].t, exp_q[i].kind, exp_q[i].data, exp_q[i].addr);
      end
    end
  endtask

  task automatic wait_valid(output bit ok, output int cyc);
    ok = 1'b0; cyc = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (valid) begin ok = 1'b1; cyc = i; return; end
    end
  endtask

  initial begin
    bit ok;
    int cyc;
    ram[0] = 24'h00FF00; ram[1] = 24'hFF0000; ram[2] = 24'h0000FF; ram[3] = 24'h0;
    m_err = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_addr", addr, 0); chk("rst_rgb", rgb, 0); chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // One frame, finishes one cycle after each valid, with spurious inputs.
    tbl.push_back(vec_t'{1,  1, 0, 0, 1, 0, 0,  24'h000000});
    tbl.push_back(vec_t'{1,  0, 0, 0, 1, 0, 0,  24'h000000});
    tbl.push_back(vec_t'{1,  0, 0, 1, 1, 0, 0,  24'h00FF00});
    tbl.push_back(vec_t'{1,  0, 1, 0, 1, 0, 1,  24'h00FF00});
    tbl.push_back(vec_t'{1,  0, 0, 0, 1, 0, 1,  24'h00FF00});
    tbl.push_back(vec_t'{1,  0, 0, 1, 1, 0, 1,  24'hFF0000});
    tbl.push_back(vec_t'{1,  1, 0, 0, 1, 0, 1,  24'hFF0000});
    tbl.push_back(vec_t'{1,  0, 1, 0, 1, 0, 2,  24'hFF0000});
    tbl.push_back(vec_t'{1,  0, 0, 0, 1, 0, 2,  24'hFF0000});
    tbl.push_back(vec_t'{1,  0, 0, 1, 1, 0, 2,  24'h0000FF});
    tbl.push_back(vec_t'{1,  0, 1, 0, 1, 0, -1, 24'h0000FF});
    tbl.push_back(vec_t'{5,  0, 0, 0, 1, 0, -1, 24'h0000FF});
    tbl.push_back(vec_t'{1,  0, 1, 0, 1, 0, -1, 24'h0000FF});
    tbl.push_back(vec_t'{13, 0, 0, 0, 1, 0, -1, 24'h0000FF});
    tbl.push_back(vec_t'{1,  0, 0, 0, 0, 1, -1, 24'h0000FF});
    tbl.push_back(vec_t'{1,  0, 1, 0, 0, 0, -1, 24'h0000FF});
    tbl.push_back(vec_t'{3,  0, 0, 0, 0, 0, -1, 24'h0000FF});
    foreach (tbl[r]) begin
      for (int j = 0; j < tbl[r].rep; j++) begin
        start = tbl[r].st; fin = tbl[r].fn;
        @(posedge clk); #1;
        chk($sformatf("tbl%0d_valid", r), valid, tbl[r].ev);
        chk($sformatf("tbl%0d_busy", r), busy, tbl[r].eb);
        chk($sformatf("tbl%0d_done", r), done, tbl[r].ed);
        chk($sformatf("tbl%0d_err", r), err, 0);
        chk($sformatf("tbl%0d_rgb", r), rgb, tbl[r].er);
        if (tbl[r].ea >= 0) chk($sformatf("tbl%0d_addr", r), addr, tbl[r].ea);
      end
    end
    start = 1'b0; fin = 1'b0;

    foreach (dly[i]) dly[i] = 30;
    run_scn("single30", 1'b0, 1);
    run_scn("cont3", 1'b1, 3);
    dly[0] = T + 5;
    run_scn("timeout", 1'b0, 1);
    dly[0] = 30;
    run_scn("errclr", 1'b0, 1);
    dly[0] = T - 1; dly[1] = 1;
    run_scn("tmo_edge", 1'b0, 1);

    for (int s = 0; s < 25; s++) begin
      bit cm;
      for (int i = 0; i < N; i++) ram[i] = 24'($urandom);
      foreach (dly[i]) begin
        int r;
        r = $urandom_range(0, 19);
        if (r < 2)       dly[i] = T + $urandom_range(0, L - 1);
        else if (r == 2) dly[i] = T - 1;
        else             dly[i] = $urandom_range(1, 25);
      end
      cm = 1'($urandom_range(0, 1));
      run_scn($sformatf("rand%0d", s), cm, cm ? $urandom_range(1, 3) : 1);
    end

    // Reset while pixel 1 is in flight, then a late finish and a fresh start.
    ram[0] = 24'h00FF00; ram[1] = 24'hFF0000; ram[2] = 24'h0000FF;
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    wait_valid(ok, cyc); chk("rs_v0_seen", ok, 1);
    fin = 1'b1; @(negedge clk); fin = 1'b0;
    wait_valid(ok, cyc); chk("rs_v1_seen", ok, 1); chk("rs_v1_addr", addr, 1);
    #2 rst_n = 1'b0; #1;
    chk("rs_async_valid", valid, 0); chk("rs_async_busy", busy, 0);
    chk("rs_async_addr", addr, 0); chk("rs_async_rgb", rgb, 0);
    chk("rs_async_done", done, 0); chk("rs_async_err", err, 0);
    m_err = 1'b0;
    @(negedge clk); rst_n = 1'b1; fin = 1'b1;
    @(negedge clk); fin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rs_late_busy", busy, 0); chk("rs_late_valid", valid, 0);
    end
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_valid(ok, cyc);
    chk("rs_restart_seen", ok, 1); chk("rs_restart_lat", cyc, 2);
    chk("rs_restart_addr", addr, 0); chk("rs_restart_rgb", rgb, 24'h00FF00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
- Sequences one full frame of NUM_LED 24-bit colour words into the single-pixel led_driver (rgb_in/valid_in/finished_led handshake).
- Fetches pixel words from a synchronous pixel RAM, hands them to the driver one at a time, then holds the line idle for the strip latch/reset gap.
- Supports single-shot frames on start_in and free-running refresh via continuous_in.
- Sits between the top level (or a frame-buffer writer) and led_driver.

Parameters:
- NUM_LED, 10, pixels per frame; must be >= 1.
- LATCH_CYCLES, 8000, idle clk_in cycles after the last pixel (80 us at 100 MHz).
- TIMEOUT_CYCLES, 4096, maximum clk_in cycles to wait for the driver's finished pulse before aborting the frame.
- IDX_W, $clog2(NUM_LED) (minimum 1), width of the pixel index.

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_n_in  input  1  reset: asynchronous assert, active-low.
- start_in  input  1  single-cycle request to send one frame; ignored unless in IDLE.
- continuous_in  input  1  while high, a new frame starts automatically after each latch gap.
- pixel_addr_out  output  IDX_W  pixel RAM read address (registered).
- pixel_data_in  input  24  pixel RAM read data; valid one cycle after the address.
- led_rgb_out  output  24  colour word to led_driver rgb_in.
- led_valid_out  output  1  one-cycle pulse to led_driver valid_in.
- led_finished_in  input  1  led_driver finished_led pulse.
- busy_out  output  1  high in any state other than IDLE.
- frame_done_out  output  1  one-cycle pulse when the latch gap of a frame completes.
- error_out  output  1  sticky flag; set on a driver timeout.

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - State goes to IDLE.
  - pixel_addr_out=0, led_rgb_out=0, led_valid_out=0, busy_out=0, frame_done_out=0, error_out=0.
  - All counters are cleared.
  - Reset asserted mid-frame aborts the frame immediately. No valid pulse is emitted after reset asserts.
- All outputs are registered.
- States: IDLE, FETCH, LOAD, WAIT, LATCH.
- IDLE:
  - On start_in: clear error_out, set index=0, set pixel_addr_out=0, go to FETCH.
  - If start_in is not high, continuous_in high in IDLE also starts a frame.
- FETCH: one cycle while the RAM read is in flight. Go to LOAD.
- LOAD:
  - Register led_rgb_out<=pixel_data_in and led_valid_out<=1.
  - Clear the timeout counter. Go to WAIT.
- Start-to-valid latency: led_valid_out is high exactly one cycle, 3 edges after the edge that samples start_in.
- WAIT:
  - led_valid_out<=0. The timeout counter increments every cycle.
  - On led_finished_in, if index<NUM_LED-1: index<=index+1, pixel_addr_out<=index+1, go to FETCH.
  - On led_finished_in, if index==NUM_LED-1: go to LATCH.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 with no finished pulse: set error_out=1 and go to LATCH (frame aborted; the remaining pixels are not sent).
  - If finished and timeout occur in the same cycle, finished wins.
- led_finished_in is sampled only in WAIT and ignored in every other state.
- LATCH:
  - The latch counter counts 0..LATCH_CYCLES-1, with led_valid_out held 0.
  - At terminal count, frame_done_out pulses for 1 cycle and the counter clears.
  - Then, if continuous_in is high: index=0, pixel_addr_out=0, go directly to FETCH.
  - Otherwise go to IDLE.
- start_in while busy_out=1 is dropped (not queued).
- The index never exceeds NUM_LED-1. With NUM_LED=1 the frame is FETCH, LOAD, WAIT, then LATCH.
- error_out stays set until reset or the next accepted start_in. A continuous_in restart does not clear it.
- Counter widths must hold LATCH_CYCLES-1 and TIMEOUT_CYCLES-1 without wrap.

Test Plan:
- NUM_LED=3, LATCH_CYCLES=20. RAM holds 0x00FF00, 0xFF0000, 0x0000FF. Pulse start_in; the driver model answers finished 30 cycles after each valid.
  -> Three valid pulses carrying those words in that order, addresses 0, 1, 2.
  -> First valid 3 cycles after start.
  -> frame_done_out pulses 20 cycles after the third finished; busy_out then drops.
- Pulse start_in again while busy mid-frame.
  -> Ignored: exactly 3 valid pulses and one frame_done_out.
- Driver model never asserts finished, TIMEOUT_CYCLES=64.
  -> error_out rises 64 cycles after the first valid; LATCH follows; only 1 valid pulse.
  -> Next start_in clears error_out.
- continuous_in held high for 3 frames.
  -> Valid pulses 1-3, 20-cycle gap, frame_done_out, next FETCH on the following cycle; 9 valid pulses total.
  -> Drop continuous_in: IDLE after the current frame.
- Assert rst_n_in low during WAIT of pixel 1.
  -> All outputs 0 asynchronously, without waiting for a clock edge.
  -> After release, a late finished pulse has no effect; a new start_in begins from address 0.
- Spurious led_finished_in in IDLE and in LATCH.
  -> No state change, no extra frame_done_out.
